// File: rtl/parking_zone_ctrl.sv
// ============================================================================
// Module      : parking_zone_ctrl
// Description : Multi-zone parking occupancy controller with runtime-loadable
//               per-zone capacities and an opening-hours FSM. All outputs are
//               registered. Optional macro PEAK_TRACK_EN adds per-zone peak
//               occupancy tracking on output peak_flat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_zone_ctrl #(
    parameter int NUM_ZONES  = 2,
    parameter int CNT_W      = 10,
    parameter int ZSEL_W     = 1,
    parameter int DEF_CAP    = 500,
    parameter int OPEN_HOUR  = 8,
    parameter int CLOSE_HOUR = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [4:0]                 hour,
    input  logic                       car_entered,
    input  logic [ZSEL_W-1:0]          entry_zone,
    input  logic                       car_exited,
    input  logic [ZSEL_W-1:0]          exit_zone,
    input  logic                       cap_wr,
    input  logic [ZSEL_W-1:0]          cap_zone,
    input  logic [CNT_W-1:0]           cap_value,
    output logic [NUM_ZONES*CNT_W-1:0] parked_flat,
    output logic [NUM_ZONES*CNT_W-1:0] vacant_flat,
    output logic [NUM_ZONES-1:0]       is_vacant,
    output logic [1:0]                 state,
    output logic                       entry_reject,
    output logic                       no_car_error,
    output logic                       capacity_error
`ifdef PEAK_TRACK_EN
    ,
    output logic [NUM_ZONES*CNT_W-1:0] peak_flat
`endif
);

    localparam logic [5:0] C_OPEN_H  = 6'(OPEN_HOUR);
    localparam logic [5:0] C_CLOSE_H = 6'(CLOSE_HOUR);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'b00,
        ST_OPEN    = 2'b01,
        ST_CLOSING = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic                 in_win;
    logic [NUM_ZONES-1:0] entry_ok;
    logic [NUM_ZONES-1:0] exit_err;
    logic [NUM_ZONES-1:0] cap_err;
    logic [NUM_ZONES-1:0] zone_empty;

    logic entry_reject_q, no_car_error_q, capacity_error_q;

    assign in_win = ({1'b0, hour} >= C_OPEN_H) && ({1'b0, hour} < C_CLOSE_H);

    // Draining takes precedence over reopening when CLOSING finds every zone empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLOSED:  if (enable && in_win)    state_d = ST_OPEN;
            ST_OPEN:    if (!in_win || !enable)  state_d = ST_CLOSING;
            ST_CLOSING: begin
                if (&zone_empty)                 state_d = ST_CLOSED;
                else if (enable && in_win)       state_d = ST_OPEN;
            end
            default:                             state_d = ST_CLOSED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_CLOSED;
            entry_reject_q   <= 1'b0;
            no_car_error_q   <= 1'b0;
            capacity_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            entry_reject_q   <= car_entered && !(|entry_ok);
            no_car_error_q   <= |exit_err;
            capacity_error_q <= |cap_err;
        end
    end

    assign state          = state_q;
    assign entry_reject   = entry_reject_q;
    assign no_car_error   = no_car_error_q;
    assign capacity_error = capacity_error_q;

    generate
        for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] cap_q, cap_d;
            logic [CNT_W-1:0] vac_q;
            logic             vac_nz_q;
            logic             ent, ext, ent_ok, ext_ok, cap_bad;

            // A same-zone exit frees the place the entry needs, so a full zone still swaps.
            always_comb begin
                ent     = car_entered && (entry_zone == ZSEL_W'(z));
                ext     = car_exited && (exit_zone == ZSEL_W'(z));
                ent_ok  = ent && (state_q == ST_OPEN) && ((cnt_q < cap_q) || ext);
                ext_ok  = ext && ((cnt_q != '0) || ent_ok);
                cnt_d   = cnt_q;
                if (ent_ok && !ext_ok)
                    cnt_d = cnt_q + CNT_W'(1);
                else if (ext_ok && !ent_ok)
                    cnt_d = cnt_q - CNT_W'(1);
                cap_d   = cap_q;
                cap_bad = 1'b0;
                if (cap_wr && (cap_zone == ZSEL_W'(z))) begin
                    if (cap_value >= cnt_d)
                        cap_d = cap_value;
                    else
                        cap_bad = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    cap_q    <= CNT_W'(DEF_CAP);
                    vac_q    <= CNT_W'(DEF_CAP);
                    vac_nz_q <= 1'b1;
                end else begin
                    cnt_q    <= cnt_d;
                    cap_q    <= cap_d;
                    vac_q    <= cap_d - cnt_d;
                    vac_nz_q <= (cap_d != cnt_d);
                end
            end

            assign entry_ok[z]   = ent_ok;
            assign exit_err[z]   = ext && !ext_ok;
            assign cap_err[z]    = cap_bad;
            assign zone_empty[z] = (cnt_q == '0);

            assign parked_flat[z*CNT_W +: CNT_W] = cnt_q;
            assign vacant_flat[z*CNT_W +: CNT_W] = vac_q;
            assign is_vacant[z]                  = vac_nz_q;

`ifdef PEAK_TRACK_EN
            logic [CNT_W-1:0] peak_q, peak_d;

            always_comb begin
                peak_d = peak_q;
                if ((state_q == ST_CLOSED) && (state_d == ST_OPEN))
                    peak_d = cnt_d;
                else if (cnt_d > peak_q)
                    peak_d = cnt_d;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    peak_q <= '0;
                else
                    peak_q <= peak_d;
            end

            assign peak_flat[z*CNT_W +: CNT_W] = peak_q;
`endif
        end
    endgenerate

endmodule

`default_nettype wire
